// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type encodings, slave FSM states
// and a byte-lane merge helper.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2
  } state_e;

  // Replace the byte lanes of old_d selected by sel with the lanes of new_d.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_d,
                                             input logic [31:0] new_d,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Next beat word index for Wishbone B3 registered-feedback bursts; o_ovf flags a
// linear burst stepping past the top of the index space.
module wb_burst_adr_gen
  import wb_pkg::*;
#(
  parameter int IW = 10
) (
  input  logic [IW-1:0] i_idx,
  input  logic [2:0]    i_cti,
  input  logic [1:0]    i_bte,
  output logic [IW-1:0] o_nxt,
  output logic          o_ovf
);

  logic [IW:0] w_inc;

  // Select the advance rule from cycle type and burst type
  always_comb begin
    w_inc = {1'b0, i_idx} + {{IW{1'b0}}, 1'b1};
    o_nxt = i_idx;
    o_ovf = 1'b0;
    if (i_cti == CTI_INC) begin
      case (i_bte)
        BTE_LINEAR: begin
          o_nxt = w_inc[IW-1:0];
          o_ovf = w_inc[IW];
        end
        BTE_WRAP4:  o_nxt = {i_idx[IW-1:2], w_inc[1:0]};
        BTE_WRAP8:  o_nxt = {i_idx[IW-1:3], w_inc[2:0]};
        BTE_WRAP16: o_nxt = {i_idx[IW-1:4], w_inc[3:0]};
        default:    o_nxt = i_idx;
      endcase
    end else begin
      o_nxt = i_idx;
    end
  end

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave SRAM with classic cycles and registered-feedback bursts:
// ack is predicted one cycle ahead and read data is prefetched from the next beat.
module wb_burst_ram
  import wb_pkg::*;
#(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int depth = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int IW = $clog2(depth);

  logic [dw-1:0] r_mem [depth];
  state_e        r_state, w_state_nxt, w_st_state;
  logic [IW-1:0] r_adr, w_adr_nxt, w_idx, w_rd_idx, w_beat_nxt;
  logic          r_ack, w_ack_nxt, r_err, w_err_nxt;
  logic [dw-1:0] r_dat, w_rd_data;
  logic          w_req, w_oor, w_hit, w_wr, w_load, w_beat_ovf, w_unused;

  assign w_idx    = wb_adr_i[IW+1:2];
  assign w_oor    = |wb_adr_i[aw-1:IW+2];
  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_hit    = (w_idx == r_adr) && !w_oor;
  assign w_wr     = r_ack & w_req & wb_we_i & w_hit;
  assign w_unused = &{1'b0, wb_adr_i[1:0]};

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;

  wb_burst_adr_gen #(.IW(IW)) u_adr_gen (
    .i_idx (r_adr),
    .i_cti (wb_cti_i),
    .i_bte (wb_bte_i),
    .o_nxt (w_beat_nxt),
    .o_ovf (w_beat_ovf)
  );

  // Target state of a fresh request, shared by IDLE and a mismatched burst beat
  always_comb begin
    w_st_state = IDLE;
    if (w_oor) begin
      w_st_state = IDLE;
    end else begin
      case (wb_cti_i)
        CTI_CONST, CTI_INC: w_st_state = BURST;
        default:            w_st_state = CLASSIC;
      endcase
    end
  end

  // Next-state, response and prefetch-address decode
  always_comb begin
    w_state_nxt = r_state;
    w_adr_nxt   = r_adr;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_idx    = r_adr;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        // the cycle right after an error pulse is the master's error cycle
        if (w_req && !r_err) begin
          w_state_nxt = w_st_state;
          w_ack_nxt   = !w_oor;
          w_err_nxt   = w_oor;
          w_adr_nxt   = w_oor ? r_adr : w_idx;
          w_rd_idx    = w_idx;
          w_load      = !w_oor && !wb_we_i;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLASSIC: w_state_nxt = IDLE;
      BURST: begin
        if (!wb_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (!wb_stb_i) begin
          w_state_nxt = BURST;
        end else if (w_hit && !r_ack) begin
          w_ack_nxt = 1'b1;
          w_load    = !wb_we_i;
        end else if (w_hit && (wb_cti_i == CTI_EOB)) begin
          w_state_nxt = IDLE;
        end else if (w_hit && w_beat_ovf) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_hit) begin
          w_ack_nxt = 1'b1;
          w_adr_nxt = w_beat_nxt;
          w_rd_idx  = w_beat_nxt;
          w_load    = !wb_we_i;
        end else begin
          w_state_nxt = w_st_state;
          w_ack_nxt   = !w_oor;
          w_err_nxt   = w_oor;
          w_adr_nxt   = w_oor ? r_adr : w_idx;
          w_rd_idx    = w_idx;
          w_load      = !w_oor && !wb_we_i;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read port with write-first bypass
  always_comb begin
    if (w_wr && (w_rd_idx == r_adr)) begin
      w_rd_data = lane_merge(r_mem[w_rd_idx], wb_dat_i, wb_sel_i);
    end else begin
      w_rd_data = r_mem[w_rd_idx];
    end
  end

  // Control and read-data registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_adr   <= {IW{1'b0}};
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= {dw{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_adr   <= w_adr_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      if (w_load) begin
        r_dat <= w_rd_data;
      end
    end
  end

  // Byte-lane memory writes on acknowledged write beats
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      r_mem[r_adr] <= lane_merge(r_mem[r_adr], wb_dat_i, wb_sel_i);
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: classic, byte lanes, wrap burst, wait/abort,
// out-of-range and address-mismatch restart.
module tb_wb_burst_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;
  int          checks   = 0;
  int          failures = 0;

  wb_burst_ram #(.dw(32), .aw(32), .depth(1024)) dut (
    .wb_clk_i (clk),   .wb_rst_ni (rst_n), .wb_adr_i (adr), .wb_dat_i (dat_i),
    .wb_sel_i (sel),   .wb_we_i   (we),    .wb_cyc_i (cyc), .wb_stb_i (stb),
    .wb_cti_i (cti),   .wb_bte_i  (bte),   .wb_dat_o (dat_o),
    .wb_ack_o (ack),   .wb_err_o  (err),   .wb_rty_o (rty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
  endtask

  task automatic bus_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    adr = a; we = w; dat_i = d; sel = s; cti = c; bte = b; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_req(a, 1'b1, d, s, 3'b000, 2'b00);
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    repeat (3) tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h exp=00000000", dat_o); end
    checks++; if (rty !== 1'b0) begin failures++; $display("FAIL rst_rty got=%b exp=0", rty); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic();
    bus_req(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL cls_wr_ack got=%b exp=1", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cls_wr_err got=%b exp=0", err); end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL cls_wr_pulse got=%b exp=0", ack); end
    bus_idle();
    tick();
    bus_req(32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL cls_rd_ack got=%b exp=1", ack); end
    checks++; if (dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL cls_rd_dat got=%h exp=deadbeef", dat_o); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cls_rd_err got=%b exp=0", err); end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL cls_rd_pulse got=%b exp=0", ack); end
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    exp_ack = 4'b0101;
    bus_req(32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ack !== exp_ack[k]) begin failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", k, ack, exp_ack[k]); end
    end
    checks++; if (dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_dat got=%h exp=deadbeef", dat_o); end
    bus_idle();
    tick();
  endtask

  task automatic test_byte_lanes();
    wb_write(32'h20, 32'h11223344, 4'hF);
    wb_write(32'h20, 32'hAABBCCDD, 4'b0101);
    bus_req(32'h20, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL lane_ack got=%b exp=1", ack); end
    checks++; if (dat_o !== 32'h11BB33DD) begin failures++; $display("FAIL lane_dat got=%h exp=11bb33dd", dat_o); end
    tick();
    bus_idle();
    tick();
  endtask

  task automatic test_wrap4();
    logic [31:0] exp_d [4];
    logic [31:0] nxt_a [4];
    exp_d = '{32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0000, 32'hC0DE0001};
    nxt_a = '{32'h08, 32'h0C, 32'h00, 32'h04};
    bus_req(32'h08, 1'b0, 32'h0, 4'hF, 3'b010, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wrap_ack[%0d] got=%b exp=1", k, ack); end
      checks++; if (dat_o !== exp_d[k]) begin failures++; $display("FAIL wrap_dat[%0d] got=%h exp=%h", k, dat_o, exp_d[k]); end
      adr = nxt_a[k];
      cti = (k == 3) ? 3'b111 : 3'b010;
    end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wrap_end got=%b exp=0", ack); end
    bus_idle();
    tick();
  endtask

  task automatic test_wait_abort();
    bus_req(32'h00, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00);
    tick();
    checks++; if (dat_o !== 32'hC0DE0000 || ack !== 1'b1) begin failures++; $display("FAIL wt_b1 got=%h/%b exp=c0de0000/1", dat_o, ack); end
    tick();
    checks++; if (dat_o !== 32'hC0DE0001 || ack !== 1'b1) begin failures++; $display("FAIL wt_b2 got=%h/%b exp=c0de0001/1", dat_o, ack); end
    adr = 32'h04;
    tick();
    adr = 32'h08; stb = 1'b0;
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wt_wait1 got=%b exp=0", ack); end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wt_wait2 got=%b exp=0", ack); end
    stb = 1'b1;
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wt_b3_ack got=%b exp=1", ack); end
    checks++; if (dat_o !== 32'hC0DE0002) begin failures++; $display("FAIL wt_b3_dat got=%h exp=c0de0002", dat_o); end
    tick();
    checks++; if (dat_o !== 32'hC0DE0003 || ack !== 1'b1) begin failures++; $display("FAIL wt_b4 got=%h/%b exp=c0de0003/1", dat_o, ack); end
    adr = 32'h0C;
    tick();
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_i = 32'hFFFFFFFF; sel = 4'hF;
    tick();
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wt_abort got=%b/%b exp=0/0", ack, err); end
    bus_idle();
    tick();
    bus_req(32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wt_idle_ack got=%b exp=1", ack); end
    checks++; if (dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL wt_nowrite got=%h exp=deadbeef", dat_o); end
    tick();
    bus_idle();
    tick();
  endtask

  task automatic test_out_of_range();
    bus_req(32'h1000, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL oor_cls got=%b/%b exp=1/0", err, ack); end
    tick();
    checks++; if (err !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL oor_cls_pulse got=%b/%b exp=0/0", err, ack); end
    bus_idle();
    tick();
    bus_req(32'hFFC, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00);
    tick();
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL oor_b0 got=%b/%b exp=1/0", ack, err); end
    checks++; if (dat_o !== 32'h0BADF00D) begin failures++; $display("FAIL oor_b0_dat got=%h exp=0badf00d", dat_o); end
    tick();
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL oor_b1 got=%b/%b exp=1/0", err, ack); end
    adr = 32'h1000;
    tick();
    checks++; if (err !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL oor_after got=%b/%b exp=0/0", err, ack); end
    bus_idle();
    tick();
  endtask

  task automatic test_mismatch();
    bus_req(32'h10, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00);
    tick();
    checks++; if (dat_o !== 32'hDEADBEEF || ack !== 1'b1) begin failures++; $display("FAIL mm_b0 got=%h/%b exp=deadbeef/1", dat_o, ack); end
    tick();
    adr = 32'h40; cti = 3'b000;
    tick();
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL mm_ack got=%b/%b exp=1/0", ack, err); end
    checks++; if (dat_o !== 32'h5A5A0040) begin failures++; $display("FAIL mm_dat got=%h exp=5a5a0040", dat_o); end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mm_pulse got=%b exp=0", ack); end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_classic();
    test_back_to_back();
    test_byte_lanes();
    for (int i = 0; i < 4; i++) begin
      wb_write(32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    end
    wb_write(32'hFFC, 32'h0BADF00D, 4'hF);
    wb_write(32'h40, 32'h5A5A0040, 4'hF);
    test_wrap4();
    test_wait_abort();
    test_out_of_range();
    test_mismatch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
